// File: rtl/capsense_scan_sequencer_pkg.sv
// Shared types and constants for the CapSense scan sequencer slice.
package capsense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ARM,
    ST_WRITE,
    ST_RELEASE,
    ST_NEXT
  } capsense_state_e;

  // Sliced down to CountWidth at the point of use.
  localparam logic [63:0] CAPSNS_TIMEOUT_CODE = '1;

  localparam int CAPSNS_DEF_SETTLE  = 16;
  localparam int CAPSNS_DEF_TIMEOUT = 4095;
  localparam int CAPSNS_TIMER_W     = 16;

endpackage

// File: rtl/capsense_scan_sequencer_if.sv
// Measure-channel start/done handshake plus result RAM write port.
interface capsense_scan_sequencer_if #(
  parameter int SensorWidth = 4,
  parameter int CountWidth  = 16
);
  logic                   meas_start;
  logic                   meas_done;
  logic [CountWidth-1:0]  raw_count;
  logic [SensorWidth-1:0] sensor_sel;
  logic                   res_we;
  logic [SensorWidth-1:0] res_waddr;
  logic [CountWidth-1:0]  res_wdata;

  modport master (
    output meas_start, sensor_sel, res_we, res_waddr, res_wdata,
    input  meas_done, raw_count
  );

  modport slave (
    input  meas_start, sensor_sel, res_we, res_waddr, res_wdata,
    output meas_done, raw_count
  );
endinterface

// File: rtl/capsense_seq_timer.sv
// Loadable down-counter shared by the settle and handshake-timeout phases.
module capsense_seq_timer #(
  parameter int Width = 16
) (
  input  logic             op_clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] value,
  input  logic             enable,
  output logic             zero
);
  logic [Width-1:0] cnt_d, cnt_q;

  // Saturates at zero so a long wait cannot wrap into a fresh count.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = value;
    else if (enable && (cnt_q != '0))
      cnt_d = cnt_q - Width'(1);
  end

  always_ff @(posedge op_clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/capsense_scan_sequencer.sv
// Steps the sensor mux through 0..sensor_last, handshaking one measurement per sensor.
module capsense_scan_sequencer
  import capsense_pkg::*;
#(
  parameter int SensorWidth   = 4,
  parameter int CountWidth    = 16,
  parameter int SettleCycles  = CAPSNS_DEF_SETTLE,
  parameter int TimeoutCycles = CAPSNS_DEF_TIMEOUT
) (
  input  logic                   op_clock,
  input  logic                   reset,
  input  logic                   go,
  input  logic                   abort,
  input  logic [SensorWidth-1:0] sensor_last,
  capsense_scan_sequencer_if.master meas_if,
  output logic                   busy,
  output logic                   scan_done,
  output logic                   timeout_err
);
  localparam logic [CAPSNS_TIMER_W-1:0] SettleLoad = CAPSNS_TIMER_W'(SettleCycles);
  // Zero is reached after exactly TimeoutCycles enabled cycles.
  localparam logic [CAPSNS_TIMER_W-1:0] TmoLoad    = CAPSNS_TIMER_W'(TimeoutCycles - 1);
  localparam logic [CountWidth-1:0]     TmoCode    = CAPSNS_TIMEOUT_CODE[CountWidth-1:0];

  capsense_state_e        state_d, state_q;
  logic [SensorWidth-1:0] sel_d, sel_q;
  logic [SensorWidth-1:0] last_d, last_q;
  logic [CountWidth-1:0]  wdata_d, wdata_q;
  logic                   meas_start_d, meas_start_q;
  logic                   res_we_d, res_we_q;
  logic                   busy_d, busy_q;
  logic                   scan_done_d, scan_done_q;
  logic                   tmo_d, tmo_q;
  logic                   seen_low_d, seen_low_q;

  logic                      tmr_load, tmr_en, tmr_zero;
  logic [CAPSNS_TIMER_W-1:0] tmr_value;

  capsense_seq_timer #(.Width(CAPSNS_TIMER_W)) u_timer (
    .op_clock (op_clock),
    .reset    (reset),
    .load     (tmr_load),
    .value    (tmr_value),
    .enable   (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    wdata_d      = wdata_q;
    meas_start_d = meas_start_q;
    res_we_d     = 1'b0;
    scan_done_d  = 1'b0;
    tmo_d        = tmo_q;
    seen_low_d   = seen_low_q;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_value    = SettleLoad;

    unique case (state_q)
      ST_IDLE: begin
        if (go && !abort) begin
          last_d   = sensor_last;
          sel_d    = '0;
          tmo_d    = 1'b0;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        tmr_en     = 1'b1;
        seen_low_d = 1'b0;
        if (tmr_zero) begin
          meas_start_d = 1'b1;
          tmr_load     = 1'b1;
          tmr_value    = TmoLoad;
          state_d      = ST_ARM;
        end
      end
      ST_ARM: begin
        tmr_en = 1'b1;
        // A done level left over from an earlier measurement must drop first.
        if (!meas_if.meas_done) seen_low_d = 1'b1;
        if (meas_if.meas_done && seen_low_q) begin
          wdata_d  = meas_if.raw_count;
          res_we_d = 1'b1;
          state_d  = ST_WRITE;
        end else if (tmr_zero) begin
          wdata_d  = TmoCode;
          tmo_d    = 1'b1;
          res_we_d = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        meas_start_d = 1'b0;
        tmr_load     = 1'b1;
        tmr_value    = TmoLoad;
        state_d      = ST_RELEASE;
      end
      ST_RELEASE: begin
        tmr_en = 1'b1;
        if (!meas_if.meas_done) begin
          state_d = ST_NEXT;
        end else if (tmr_zero) begin
          tmo_d   = 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (sel_q == last_q) begin
          scan_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          sel_d    = sel_q + SensorWidth'(1);
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      meas_start_d = 1'b0;
      res_we_d     = 1'b0;
      scan_done_d  = 1'b0;
      sel_d        = sel_q;
      tmo_d        = tmo_q;
      wdata_d      = wdata_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge op_clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      last_q       <= '0;
      wdata_q      <= '0;
      meas_start_q <= 1'b0;
      res_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      scan_done_q  <= 1'b0;
      tmo_q        <= 1'b0;
      seen_low_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      wdata_q      <= wdata_d;
      meas_start_q <= meas_start_d;
      res_we_q     <= res_we_d;
      busy_q       <= busy_d;
      scan_done_q  <= scan_done_d;
      tmo_q        <= tmo_d;
      seen_low_q   <= seen_low_d;
    end
  end

  assign meas_if.meas_start = meas_start_q;
  assign meas_if.sensor_sel = sel_q;
  assign meas_if.res_we     = res_we_q;
  assign meas_if.res_waddr  = sel_q;
  assign meas_if.res_wdata  = wdata_q;
  assign busy               = busy_q;
  assign scan_done          = scan_done_q;
  assign timeout_err        = tmo_q;
endmodule
